mcse_resource_arbiter: RTL and testbench
========================================

// Module: mcse_resource_arbiter
// PURPOSE
//  N-client successor to the two-way secure-boot/FW-auth steering mux in the MCSE control unit.
//  It arbitrates exclusive ownership of three shared resources among N security sub-controllers:
//    - the secure-memory port;
//    - the bus-translation port;
//    - the SHA port.
//  The owner's request packets are routed to the resources; all other clients are isolated.
//  Adds request/release handshakes, round-robin or fixed-priority selection, a watchdog revoke
//  and a safe drain of an outstanding bus transaction.
// PARAMETERS
//  N_CLIENTS   4    number of client controllers (>=2)
//  MEM_PKT_W   266  memory pkt {rd_en,wr_en,addr[7:0],wrdata[255:0]}
//  BUS_PKT_W   162  bus pkt {go,rw,addr[31:0],wrdata[127:0]}
//  SHA_PKT_W   515  sha pkt {sel,next,init,block[511:0]}
//  TIMEOUT_W   16   watchdog counter width
//  FIXED_PRIO  0    0: round-robin; 1: lowest index wins
// PORTS
//  clk             in   1                   clock
//  rst             in   1                   async reset, active-high
//  cfg_timeout     in   TIMEOUT_W           max owned cycles; 0 disables the watchdog
//  req             in   N_CLIENTS           per-client ownership request (level)
//  rel             in   N_CLIENTS           per-client release pulse
//  grant           out  N_CLIENTS           one-hot ownership
//  owner_idx       out  $clog2(N_CLIENTS)   index of the current or last owner
//  owner_valid     out  1                   a grant is active
//  timeout_evt     out  1                   1-cycle pulse on watchdog revoke
//  cl_mem_pkt      in   N_CLIENTS*MEM_PKT_W packed client memory pkts; client i at slice i
//  mem_pkt         out  MEM_PKT_W           to secure memory
//  cl_bus_pkt      in   N_CLIENTS*BUS_PKT_W packed client bus pkts
//  bus_pkt         out  BUS_PKT_W           to bus translation unit
//  bus_done        in   1                   bus transaction complete
//  cl_bus_done     out  N_CLIENTS           bus_done routed to the owner only
//  cl_sha_pkt      in   N_CLIENTS*SHA_PKT_W packed client SHA pkts
//  sha_pkt         out  SHA_PKT_W           to SHA core
// BEHAVIOUR
//  Reset (asynchronous)
//   - Outputs: all zero; state IDLE; rr_ptr=0; timer=0; outstanding=0.
//  FSM states: IDLE, GRANT, DRAIN. Registered state; output muxing is combinational from state/owner.
//  IDLE
//   - If any req is set, select the winner:
//     - FIXED_PRIO=1: lowest index.
//     - FIXED_PRIO=0: first req at index >= rr_ptr, wrapping modulo N_CLIENTS.
//   - On that edge: state->GRANT, grant[w]=1, owner_idx=w, owner_valid=1, timer=0.
//   - Latency: req high at edge k -> grant high after edge k+1.
//  GRANT
//   - mem_pkt/bus_pkt/sha_pkt = owner's slices; cl_bus_done[owner]=bus_done; all else 0.
//   - outstanding: set when bus_pkt.go=1 and bus_done=0; cleared when bus_done=1.
//   - Release condition: rel[owner]=1, or req[owner]=0.
//     - On release: rr_ptr=(owner+1) mod N; grant<=0.
//     - Next state is DRAIN if outstanding (or go=1 with done=0 this cycle), else IDLE.
//   - Watchdog: timer increments every GRANT cycle.
//     - If cfg_timeout!=0 and timer==cfg_timeout-1 with no release: forced release as above.
//     - timeout_evt=1 for that cycle.
//     - Release and timeout in the same cycle: release wins, no timeout_evt.
//  DRAIN
//   - grant=0 and all output pkts zero (go is not reasserted).
//   - cl_bus_done[owner_idx] still receives bus_done.
//   - On bus_done: state->IDLE.
//   - Watchdog continues: expiry in DRAIN gives timeout_evt and forces IDLE, clearing outstanding.
//  Isolation
//   - At least one all-zero IDLE cycle between any two grants, including a re-grant to the same client.
//   - Non-owner reqs wait; they are never dropped or queued beyond the level.
//   - rel from a non-owner is ignored.
//  Widths and values
//   - owner_idx holds its last value when owner_valid=0.
//   - timer saturates; it never wraps.
//   - rr_ptr wraps from N_CLIENTS-1 to 0.
// TESTING
//  1. RR: req=4'b1111 held, each owner rels after 3 cycles -> grant order 0,1,2,3,0 with one idle cycle between grants.
//  2. FIXED_PRIO=1: req=4'b1010 -> grant[1]. Client 1 rels, req=4'b1000 -> grant[3] only after one idle cycle.
//  3. Isolation: owner 2; client 0 drives go=1, addr=32'hDEAD -> bus_pkt carries client 2 data; cl_bus_done[0]=0.
//  4. Drain: owner issues go, rels before bus_done; done arrives 5 cycles later -> DRAIN 5 cycles, outputs 0, then IDLE.
//  5. Watchdog: cfg_timeout=10, owner never rels -> timeout_evt exactly 10 cycles after grant, grant drops, next client granted.
//  6. Reset mid-GRANT: rst=1 asynchronously -> grant/pkts 0 immediately; after rst=0, rr_ptr=0 so client 0 wins first.

Source files
------------

// File: rtl/mcse_resource_arbiter.sv
// Exclusive-ownership arbiter for the MCSE secure-memory, bus-translation and SHA ports.
// One client at a time owns all three ports; every other client sees them as isolated.
module mcse_resource_arbiter #(
    parameter int N_CLIENTS  = 4,
    parameter int MEM_PKT_W  = 266,
    parameter int BUS_PKT_W  = 162,
    parameter int SHA_PKT_W  = 515,
    parameter int TIMEOUT_W  = 16,
    parameter int FIXED_PRIO = 0,
    localparam int IDX_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [TIMEOUT_W-1:0]           cfg_timeout,
    input  logic [N_CLIENTS-1:0]           req,
    input  logic [N_CLIENTS-1:0]           rel,
    output logic [N_CLIENTS-1:0]           grant,
    output logic [IDX_W-1:0]               owner_idx,
    output logic                           owner_valid,
    output logic                           timeout_evt,
    input  logic [N_CLIENTS*MEM_PKT_W-1:0] cl_mem_pkt,
    output logic [MEM_PKT_W-1:0]           mem_pkt,
    input  logic [N_CLIENTS*BUS_PKT_W-1:0] cl_bus_pkt,
    output logic [BUS_PKT_W-1:0]           bus_pkt,
    input  logic                           bus_done,
    output logic [N_CLIENTS-1:0]           cl_bus_done,
    input  logic [N_CLIENTS*SHA_PKT_W-1:0] cl_sha_pkt,
    output logic [SHA_PKT_W-1:0]           sha_pkt
);

    // state | meaning
    // IDLE  | no owner, all ports zero; picks a winner when any req is set
    // GRANT | owner_idx drives the ports and receives bus_done
    // DRAIN | ownership revoked, waiting for an in-flight bus transaction
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       owner_nxt;
    logic [IDX_W-1:0]       rr_ptr, rr_ptr_nxt;
    logic [TIMEOUT_W-1:0]   timer, timer_nxt, timer_inc;
    logic                   outstanding, outstanding_nxt;
    logic                   timeout_nxt;
    logic [IDX_W-1:0]       winner;
    logic                   any_req;
    logic                   owner_rel;
    logic                   wd_hit;
    logic                   bus_live;
    logic                   owner_go;

    logic [MEM_PKT_W-1:0]   mem_arr [N_CLIENTS];
    logic [BUS_PKT_W-1:0]   bus_arr [N_CLIENTS];
    logic [SHA_PKT_W-1:0]   sha_arr [N_CLIENTS];

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_unpack
        assign mem_arr[i] = cl_mem_pkt[i*MEM_PKT_W +: MEM_PKT_W];
        assign bus_arr[i] = cl_bus_pkt[i*BUS_PKT_W +: BUS_PKT_W];
        assign sha_arr[i] = cl_sha_pkt[i*SHA_PKT_W +: SHA_PKT_W];
    end

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_CLIENTS) sum = sum - N_CLIENTS;
        return IDX_W'(sum);
    endfunction

    // Scan from the far end so the lowest offset from the start point wins.
    always_comb begin
        winner = '0;
        for (int k = N_CLIENTS - 1; k >= 0; k--) begin
            if (FIXED_PRIO != 0) begin
                if (req[IDX_W'(k)]) winner = IDX_W'(k);
            end else begin
                if (req[rr_index(rr_ptr, k)]) winner = rr_index(rr_ptr, k);
            end
        end
    end

    assign any_req   = |req;
    assign owner_go  = bus_arr[owner_idx][BUS_PKT_W-1];
    assign owner_rel = rel[owner_idx] | ~req[owner_idx];
    assign wd_hit    = (cfg_timeout != '0) && (timer == cfg_timeout - TIMEOUT_W'(1));
    assign timer_inc = (timer == '1) ? timer : timer + TIMEOUT_W'(1);
    assign bus_live  = bus_done ? 1'b0 : (outstanding | owner_go);

    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner_idx;
        rr_ptr_nxt      = rr_ptr;
        timer_nxt       = timer;
        outstanding_nxt = outstanding;
        timeout_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt       = GRANT;
                    owner_nxt       = winner;
                    timer_nxt       = '0;
                    outstanding_nxt = 1'b0;
                end
            end
            GRANT: begin
                timer_nxt       = timer_inc;
                outstanding_nxt = bus_live;
                if (owner_rel || wd_hit) begin
                    rr_ptr_nxt  = (owner_idx == IDX_W'(N_CLIENTS - 1)) ? '0 : owner_idx + IDX_W'(1);
                    state_nxt   = bus_live ? DRAIN : IDLE;
                    // A voluntary release in the expiry cycle is not a revoke.
                    timeout_nxt = ~owner_rel;
                end
            end
            DRAIN: begin
                timer_nxt = timer_inc;
                if (bus_done) begin
                    state_nxt       = IDLE;
                    outstanding_nxt = 1'b0;
                end else if (wd_hit) begin
                    state_nxt       = IDLE;
                    outstanding_nxt = 1'b0;
                    timeout_nxt     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant       = '0;
        owner_valid = 1'b0;
        mem_pkt     = '0;
        bus_pkt     = '0;
        sha_pkt     = '0;
        cl_bus_done = '0;
        if (state == GRANT) begin
            grant[owner_idx]       = 1'b1;
            owner_valid            = 1'b1;
            mem_pkt                = mem_arr[owner_idx];
            bus_pkt                = bus_arr[owner_idx];
            sha_pkt                = sha_arr[owner_idx];
            cl_bus_done[owner_idx] = bus_done;
        end else if (state == DRAIN) begin
            cl_bus_done[owner_idx] = bus_done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner_idx   <= '0;
            rr_ptr      <= '0;
            timer       <= '0;
            outstanding <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner_idx   <= owner_nxt;
            rr_ptr      <= rr_ptr_nxt;
            timer       <= timer_nxt;
            outstanding <= outstanding_nxt;
            timeout_evt <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_mcse_resource_arbiter.sv
// Scoreboard bench for mcse_resource_arbiter: round-robin and fixed-priority instances,
// directed scenarios push expected grants/revokes, a negedge monitor pops and compares.
module tb_mcse_resource_arbiter;
    localparam int N  = 4;
    localparam int MW = 266;
    localparam int BW = 162;
    localparam int SW = 515;
    localparam int TW = 16;

    typedef struct {
        int idx;
        int gap;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [TW-1:0]   cfg_timeout;
    logic [N-1:0]    req, req_fp, rel;
    logic [N*MW-1:0] cl_mem_pkt;
    logic [N*BW-1:0] cl_bus_pkt;
    logic [N*SW-1:0] cl_sha_pkt;
    logic            bus_done;

    logic [N-1:0]    grant, grant_fp, cl_bus_done, cl_bus_done_fp;
    logic [1:0]      owner_idx, owner_idx_fp;
    logic            owner_valid, owner_valid_fp, timeout_evt, timeout_evt_fp;
    logic [MW-1:0]   mem_pkt, mem_pkt_fp;
    logic [BW-1:0]   bus_pkt, bus_pkt_fp;
    logic [SW-1:0]   sha_pkt, sha_pkt_fp;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_rr[$];
    exp_t exp_fp[$];
    int   exp_to[$];

    always #5 clk = ~clk;

    mcse_resource_arbiter #(.N_CLIENTS(N), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .cfg_timeout(cfg_timeout), .req(req), .rel(rel),
        .grant(grant), .owner_idx(owner_idx), .owner_valid(owner_valid),
        .timeout_evt(timeout_evt), .cl_mem_pkt(cl_mem_pkt), .mem_pkt(mem_pkt),
        .cl_bus_pkt(cl_bus_pkt), .bus_pkt(bus_pkt), .bus_done(bus_done),
        .cl_bus_done(cl_bus_done), .cl_sha_pkt(cl_sha_pkt), .sha_pkt(sha_pkt));

    mcse_resource_arbiter #(.N_CLIENTS(N), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst), .cfg_timeout(cfg_timeout), .req(req_fp), .rel(rel),
        .grant(grant_fp), .owner_idx(owner_idx_fp), .owner_valid(owner_valid_fp),
        .timeout_evt(timeout_evt_fp), .cl_mem_pkt(cl_mem_pkt), .mem_pkt(mem_pkt_fp),
        .cl_bus_pkt(cl_bus_pkt), .bus_pkt(bus_pkt_fp), .bus_done(bus_done),
        .cl_bus_done(cl_bus_done_fp), .cl_sha_pkt(cl_sha_pkt), .sha_pkt(sha_pkt_fp));

    function automatic logic [MW-1:0] mem_of(input int i);
        return {2'b01, 8'(8'h10 + i), {8{32'hC0DE_0000 + 32'(i)}}};
    endfunction

    function automatic logic [BW-1:0] bus_of(input int i, input logic go);
        return {go, 1'b1, 32'h1000_0000 + 32'(i), {4{32'hB0B0_0000 + 32'(i)}}};
    endfunction

    function automatic logic [SW-1:0] sha_of(input int i);
        return {3'b001, {16{32'h5AA5_0000 + 32'(i)}}};
    endfunction

    task automatic check(input string name, input logic [519:0] act, input logic [519:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_rr(input int idx, input int gap);
        exp_t e;
        e.idx = idx;
        e.gap = gap;
        exp_rr.push_back(e);
    endtask

    task automatic push_fp(input int idx, input int gap);
        exp_t e;
        e.idx = idx;
        e.gap = gap;
        exp_fp.push_back(e);
    endtask

    task automatic set_bus(input int i, input logic [BW-1:0] v);
        cl_bus_pkt[i*BW +: BW] = v;
    endtask

    task automatic wait_owner(input int which, input int idx);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge clk);
            if (which == 0) hit = owner_valid && (owner_idx == 2'(idx));
            else            hit = owner_valid_fp && (owner_idx_fp == 2'(idx));
        end
        if (!hit) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_owner%0d: no grant to client %0d within 60 cycles", which, idx);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every new grant and every revoke pulse against the queues.
    int         gap_rr = 0, gap_fp = 0, owned = 0;
    logic       pv_rr = 1'b0, pv_fp = 1'b0;
    initial begin
        exp_t       e;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            if (owner_valid && !pv_rr) begin
                if (exp_rr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL grant_rr: actual owner %0d, required no grant", owner_idx);
                end else begin
                    e  = exp_rr.pop_front();
                    oh = 4'b0001 << e.idx;
                    check("grant_rr_idx", 520'(owner_idx), 520'(e.idx));
                    check("grant_rr_vec", 520'(grant), 520'(oh));
                    if (e.gap >= 0) check("idle_gap_rr", 520'(gap_rr), 520'(e.gap));
                end
                owned = 0;
            end
            if (owner_valid) begin
                owned++;
                gap_rr = 0;
            end else begin
                gap_rr++;
            end
            if (timeout_evt) begin
                if (exp_to.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL timeout_rr: actual pulse after %0d owned cycles, required none", owned);
                end else begin
                    check("wd_owned_cycles", 520'(owned), 520'(exp_to.pop_front()));
                end
            end
            pv_rr = owner_valid;

            if (owner_valid_fp && !pv_fp) begin
                if (exp_fp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL grant_fp: actual owner %0d, required no grant", owner_idx_fp);
                end else begin
                    e  = exp_fp.pop_front();
                    oh = 4'b0001 << e.idx;
                    check("grant_fp_idx", 520'(owner_idx_fp), 520'(e.idx));
                    check("grant_fp_vec", 520'(grant_fp), 520'(oh));
                    check("mem_fp", 520'(mem_pkt_fp), 520'(mem_of(e.idx)));
                    check("bus_fp", 520'(bus_pkt_fp), 520'(bus_of(e.idx, 1'b0)));
                    check("sha_fp", 520'(sha_pkt_fp), 520'(sha_of(e.idx)));
                    check("bus_done_fp", 520'(cl_bus_done_fp), 520'(0));
                    if (e.gap >= 0) check("idle_gap_fp", 520'(gap_fp), 520'(e.gap));
                end
            end
            gap_fp = owner_valid_fp ? 0 : gap_fp + 1;
            if (timeout_evt_fp) begin
                n_tests++;
                n_fail++;
                $display("FAIL timeout_fp: actual pulse, required none");
            end
            pv_fp = owner_valid_fp;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst         = 1'b1;
        cfg_timeout = '0;
        req         = '0;
        req_fp      = '0;
        rel         = '0;
        bus_done    = 1'b1;
        for (int i = 0; i < N; i++) begin
            cl_mem_pkt[i*MW +: MW] = mem_of(i);
            cl_sha_pkt[i*SW +: SW] = sha_of(i);
            set_bus(i, bus_of(i, 1'b0));
        end

        // Reset state
        @(negedge clk);
        check("rst_owner_valid", 520'(owner_valid), 520'(0));
        check("rst_grant", 520'(grant), 520'(0));
        check("rst_owner_idx", 520'(owner_idx), 520'(0));
        check("rst_timeout_evt", 520'(timeout_evt), 520'(0));
        check("rst_mem", 520'(mem_pkt), 520'(0));
        check("rst_bus", 520'(bus_pkt), 520'(0));
        check("rst_sha", 520'(sha_pkt), 520'(0));
        check("rst_cl_bus_done", 520'(cl_bus_done), 520'(0));
        @(negedge clk);
        rst      = 1'b0;
        bus_done = 1'b0;
        tick(2);

        // Round-robin rotation with every owner releasing after 3 cycles
        push_rr(0, -1);
        push_rr(1, 1);
        push_rr(2, 1);
        push_rr(3, 1);
        push_rr(0, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_owner(0, k % N);
            tick(3);
            rel[k % N] = 1'b1;
            tick(1);
            rel = '0;
            if (k == 4) req = '0;
        end
        tick(3);

        // Isolation: client 0 drives traffic while client 2 owns the ports
        push_rr(2, -1);
        set_bus(0, {1'b1, 1'b0, 32'h0000_DEAD, 128'h0});
        req = 4'b0100;
        wait_owner(0, 2);
        check("iso_mem", 520'(mem_pkt), 520'(mem_of(2)));
        check("iso_bus", 520'(bus_pkt), 520'(bus_of(2, 1'b0)));
        check("iso_sha", 520'(sha_pkt), 520'(sha_of(2)));
        tick(1);
        bus_done = 1'b1;
        @(negedge clk);
        check("iso_cl_bus_done", 520'(cl_bus_done), 520'(4'b0100));
        tick(1);
        bus_done = 1'b0;
        req      = '0;
        set_bus(0, bus_of(0, 1'b0));
        tick(3);

        // Drain: client 3 releases with a bus transaction still open
        push_rr(3, -1);
        req = 4'b1000;
        wait_owner(0, 3);
        tick(1);
        set_bus(3, bus_of(3, 1'b1));
        @(negedge clk);
        check("drain_bus_go", 520'(bus_pkt), 520'(bus_of(3, 1'b1)));
        tick(1);
        rel[3] = 1'b1;
        push_rr(2, 6);
        tick(1);
        rel = '0;
        req = 4'b0100;
        @(negedge clk);
        check("drain_owner_valid", 520'(owner_valid), 520'(0));
        check("drain_grant", 520'(grant), 520'(0));
        check("drain_bus_quiet", 520'(bus_pkt), 520'(0));
        check("drain_mem_quiet", 520'(mem_pkt), 520'(0));
        check("drain_owner_idx", 520'(owner_idx), 520'(3));
        tick(4);
        bus_done = 1'b1;
        @(negedge clk);
        check("drain_cl_bus_done", 520'(cl_bus_done), 520'(4'b1000));
        tick(1);
        bus_done = 1'b0;
        set_bus(3, bus_of(3, 1'b0));
        wait_owner(0, 2);
        tick(1);
        req = '0;
        tick(3);

        // Watchdog: client 0 is revoked, client 1 releases in its expiry cycle
        cfg_timeout = 16'd10;
        push_rr(0, -1);
        exp_to.push_back(10);
        push_rr(1, 1);
        req = 4'b0011;
        wait_owner(0, 0);
        wait_owner(0, 1);
        tick(9);
        rel[1] = 1'b1;
        req    = '0;
        tick(1);
        rel = '0;
        tick(3);
        check("wd_revokes_seen", 520'(exp_to.size()), 520'(0));
        cfg_timeout = '0;

        // Fixed priority instance
        push_fp(1, -1);
        push_fp(3, 1);
        req_fp = 4'b1010;
        wait_owner(1, 1);
        tick(1);
        rel[1] = 1'b1;
        req_fp = 4'b1000;
        tick(1);
        rel = '0;
        wait_owner(1, 3);
        tick(1);
        req_fp = '0;
        tick(3);
        push_fp(1, -1);
        push_fp(0, 1);
        req_fp = 4'b0110;
        wait_owner(1, 1);
        tick(1);
        rel[1] = 1'b1;
        req_fp = 4'b1001;
        tick(1);
        rel = '0;
        wait_owner(1, 0);
        tick(1);
        req_fp = '0;
        tick(3);

        // Asynchronous reset in the middle of a grant
        push_rr(2, -1);
        req = 4'b0100;
        wait_owner(0, 2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_owner_valid", 520'(owner_valid), 520'(0));
        check("arst_grant", 520'(grant), 520'(0));
        check("arst_mem", 520'(mem_pkt), 520'(0));
        check("arst_bus", 520'(bus_pkt), 520'(0));
        check("arst_sha", 520'(sha_pkt), 520'(0));
        check("arst_owner_idx", 520'(owner_idx), 520'(0));
        tick(1);
        req = 4'b1111;
        push_rr(0, -1);
        @(negedge clk);
        rst = 1'b0;
        wait_owner(0, 0);
        tick(1);
        req = '0;
        tick(5);

        check("rr_queue_empty", 520'(exp_rr.size()), 520'(0));
        check("fp_queue_empty", 520'(exp_fp.size()), 520'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
